sevenseg_scan_ctrl: RTL and testbench
=====================================

// Module: sevenseg_scan_ctrl
// PURPOSE
//  Scan controller and source arbiter for the 8-digit multiplexed seven-segment display.
//  - Picks either the core debug word or the MMIO display word and latches it once per frame (no tearing).
//  - Sequences the digit scan with anti-ghost blanking, 8-level brightness PWM, digit masking and leading-zero suppression.
//  - Drives the board pins an/sev_out/dp directly.
// PARAMETERS
//  BLANK_CYC  2  cycles per digit with all anodes off before the digit is lit (>=1)
//  ON_STEP    4  cycles per brightness step; the lit phase lasts 8*ON_STEP cycles (>=1)
// PORTS
//  clk_7seg   in   1   scan clock
//  Rst        in   1   reset, synchronous, active-high
//  core_sel   in   1   1 = show core_data (prog|debug), 0 = show mmio_data
//  core_data  in   32  core debug word
//  mmio_data  in   32  MMIO display word
//  digit_en   in   8   per-digit enable; bit i = digit i (nibble i)
//  lz_en      in   1   leading-zero suppression enable
//  bright     in   3   brightness: lit for (bright+1)/8 of the ON phase
//  dp_mask    in   8   decimal point request per digit
//  an         out  8   anodes, active-low one-hot
//  sev_out    out  7   segments {a,b,c,d,e,f,g}, active-low
//  dp         out  1   decimal point, active-low
//  frame_done out  1   1-cycle pulse on the last cycle of digit 7's ON phase
//  src_core   out  1   source latched for the current frame (1 = core)
// BEHAVIOUR
//  Reset: state=S_LATCH, idx=0, an=8'hFF, sev_out=7'h7F, dp=1, frame_done=0, src_core=0, frame_q=0.
//  Rst asserted mid-frame aborts the frame at the next edge. Pins return to reset values in that same edge.
//  FSM:
//   - S_LATCH (1 cycle): frame_q <= core_sel ? core_data : mmio_data; src_core <= core_sel; idx <= 0; goto S_BLANK.
//   - S_BLANK (BLANK_CYC cycles, blank_cnt 0..BLANK_CYC-1): an=FF, sev_out=7F, dp=1; then goto S_ON with on_cnt=0.
//   - S_ON (8*ON_STEP cycles, on_cnt 0..8*ON_STEP-1): at on_cnt end:
//       - if idx==7: goto S_LATCH;
//       - else idx <= idx+1 and goto S_BLANK.
//  Frame length: 1 + 8*(BLANK_CYC + 8*ON_STEP) cycles.
//  core_sel / core_data / mmio_data changes take effect only at the next S_LATCH. Width/config inputs are sampled live.
//  Digit idx is lit in S_ON iff all of the following hold:
//   - digit_en[idx];
//   - !suppressed(idx);
//   - on_cnt < (bright+1)*ON_STEP. Compare in a width of clog2(8*ON_STEP)+1; no overflow at bright=7.
//  suppressed(i) = lz_en && i!=0 && frame_q[31:4*i]==0. Digit 0 is never suppressed.
//  When lit: an = ~(8'b1<<idx), sev_out = decode(frame_q[4*idx+:4]), dp = ~dp_mask[idx].
//  When not lit: an=FF, sev_out=7F, dp=1.
//  an/sev_out/dp are registers aligned with the state: the value shown in a cycle corresponds to that cycle's state and counters. They must be glitch-free.
//  Decode (hex 0..F):
//   01,4F,12,06,4C,24,20,0F,00,04,08,60,31,42,30,38
//  frame_done = (state==S_ON && idx==7 && on_cnt==8*ON_STEP-1), registered with the same alignment.
//  The counters wrap only via the FSM transitions above. No free-running overflow.
// STRUCTURE
//  Package sevenseg_pkg holds:
//   - typedef enum logic [1:0] {S_LATCH, S_BLANK, S_ON} scan_state_t;
//   - localparam SEG_BLANK = 7'h7F, AN_OFF = 8'hFF;
//   - function seg_decode(logic [3:0]) -> logic [6:0].
//  Sub-module sevenseg_decoder: combinational nibble -> segment ROM, wrapping seg_decode.
//  The top-level instantiates this block in place of its inline an/seg logic, with core_sel = prog|debug.
// TESTING  (BLANK_CYC=2, ON_STEP=1; frame = 81 cycles)
//  1. Reset, core_sel=0, mmio_data=32'h8765_4321, digit_en=FF, bright=7:
//     - S_LATCH, 2 blank cycles, then an=FE, sev_out=4F for 8 cycles;
//     - then an=FD, sev_out=12 after 2 blank cycles;
//     - frame_done pulses at cycle 80 after the first S_LATCH.
//  2. bright=0:
//     - each digit is lit only at on_cnt=0 (an one-hot for 1 cycle), then an=FF for the remaining 7 cycles;
//     - bright=3 gives 4 lit cycles.
//  3. lz_en=1, mmio_data=32'h0000_00A0:
//     - digits 0,1 lit (sev_out=01, then 08);
//     - digits 2..7 keep an=FF;
//     - with mmio_data=0, only digit 0 is lit, showing 01.
//  4. Switch core_sel 0->1 mid-frame with core_data=32'hFFFF_FFFF:
//     - the current frame still shows mmio_data and src_core stays 0;
//     - the next S_LATCH sets src_core=1 and all digits show 38.
//  5. digit_en=8'h0F, dp_mask=8'h01: digits 4..7 keep an=FF; dp=0 only while digit 0 is lit.
//  6. Rst asserted during digit 5's ON phase:
//     - next edge an=FF, sev_out=7F, frame_done=0;
//     - after release, the sequence restarts at S_LATCH with digit 0.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types, pin constants and the hex-to-segment table for the seven-segment scan controller.
package sevenseg_pkg;

    typedef enum logic [1:0] {S_LATCH, S_BLANK, S_ON} scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low segments ordered {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h60;
            4'hC: seg = 7'h31;
            4'hD: seg = 7'h42;
            4'hE: seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational nibble-to-segment ROM.
module sevenseg_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = seg_decode(nibble);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller: per-frame source latch,
// anti-ghost blanking, brightness PWM, digit masking and leading-zero suppression.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int BLANK_CYC = 2,
    parameter int ON_STEP   = 4
) (
    input  logic        clk_7seg,
    input  logic        Rst,
    input  logic        core_sel,
    input  logic [31:0] core_data,
    input  logic [31:0] mmio_data,
    input  logic [7:0]  digit_en,
    input  logic        lz_en,
    input  logic [2:0]  bright,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  sev_out,
    output logic        dp,
    output logic        frame_done,
    output logic        src_core
);

    localparam int ON_LEN  = 8 * ON_STEP;
    localparam int ON_W    = $clog2(ON_LEN) + 1;
    localparam int BLANK_W = $clog2(BLANK_CYC) + 1;

    scan_state_t        state_reg, state_next;
    logic [2:0]         idx_reg, idx_next;
    logic [BLANK_W-1:0] blank_cnt_reg, blank_cnt_next;
    logic [ON_W-1:0]    on_cnt_reg, on_cnt_next;
    logic [31:0]        frame_q_reg, frame_q_next;
    logic               src_core_reg, src_core_next;

    logic [7:0]         an_reg, an_next;
    logic [6:0]         sev_reg, sev_next;
    logic               dp_reg, dp_next;
    logic               frame_done_reg, frame_done_next;

    logic [7:0]         upper_zero;
    logic [ON_W-1:0]    on_thresh;
    logic [6:0]         dec_seg;
    logic               lit;

    // upper_zero[i]: every nibble from i upward is zero; digit 0 can never be blanked.
    assign upper_zero[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_upper_zero
            assign upper_zero[gi] = (frame_q_reg[31:4*gi] == '0);
        end
    endgenerate

    assign on_thresh = (ON_W'(bright) + ON_W'(1)) * ON_W'(ON_STEP);

    sevenseg_decoder u_decoder (
        .nibble (frame_q_reg[{idx_next, 2'b00} +: 4]),
        .seg    (dec_seg)
    );

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        blank_cnt_next = blank_cnt_reg;
        on_cnt_next    = on_cnt_reg;
        frame_q_next   = frame_q_reg;
        src_core_next  = src_core_reg;
        case (state_reg)
            S_LATCH: begin
                frame_q_next   = core_sel ? core_data : mmio_data;
                src_core_next  = core_sel;
                idx_next       = 3'd0;
                blank_cnt_next = '0;
                state_next     = S_BLANK;
            end
            S_BLANK: begin
                if (blank_cnt_reg == BLANK_W'(BLANK_CYC - 1)) begin
                    on_cnt_next = '0;
                    state_next  = S_ON;
                end else begin
                    blank_cnt_next = blank_cnt_reg + BLANK_W'(1);
                end
            end
            S_ON: begin
                if (on_cnt_reg == ON_W'(ON_LEN - 1)) begin
                    if (idx_reg == 3'd7) begin
                        state_next = S_LATCH;
                    end else begin
                        idx_next       = idx_reg + 3'd1;
                        blank_cnt_next = '0;
                        state_next     = S_BLANK;
                    end
                end else begin
                    on_cnt_next = on_cnt_reg + ON_W'(1);
                end
            end
            default: state_next = S_LATCH;
        endcase
    end

    // Pins are computed from the upcoming state so the registered value lines up with it.
    // frame_q only changes on the way out of S_LATCH, never while entering S_ON.
    always_comb begin
        lit = (state_next == S_ON) && digit_en[idx_next]
              && !(lz_en && upper_zero[idx_next])
              && (on_cnt_next < on_thresh);
        an_next         = AN_OFF;
        sev_next        = SEG_BLANK;
        dp_next         = 1'b1;
        frame_done_next = (state_next == S_ON) && (idx_next == 3'd7)
                          && (on_cnt_next == ON_W'(ON_LEN - 1));
        if (lit) begin
            an_next  = ~(8'b1 << idx_next);
            sev_next = dec_seg;
            dp_next  = ~dp_mask[idx_next];
        end
    end

    always_ff @(posedge clk_7seg) begin
        if (Rst) begin
            state_reg      <= S_LATCH;
            idx_reg        <= 3'd0;
            blank_cnt_reg  <= '0;
            on_cnt_reg     <= '0;
            frame_q_reg    <= '0;
            src_core_reg   <= 1'b0;
            an_reg         <= AN_OFF;
            sev_reg        <= SEG_BLANK;
            dp_reg         <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            blank_cnt_reg  <= blank_cnt_next;
            on_cnt_reg     <= on_cnt_next;
            frame_q_reg    <= frame_q_next;
            src_core_reg   <= src_core_next;
            an_reg         <= an_next;
            sev_reg        <= sev_next;
            dp_reg         <= dp_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign an         = an_reg;
    assign sev_out    = sev_reg;
    assign dp         = dp_reg;
    assign frame_done = frame_done_reg;
    assign src_core   = src_core_reg;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl: per-cycle pin expectations from a frame-position model.
module tb_sevenseg_scan_ctrl;

    localparam int BLANK_CYC = 2;
    localparam int ON_STEP   = 1;
    localparam int DIG_CYC   = BLANK_CYC + 8 * ON_STEP;
    localparam int FRAME     = 1 + 8 * DIG_CYC;

    logic        clk_7seg = 1'b0;
    logic        Rst = 1'b1;
    logic        core_sel = 1'b0;
    logic [31:0] core_data = '0;
    logic [31:0] mmio_data = '0;
    logic [7:0]  digit_en = '0;
    logic        lz_en = 1'b0;
    logic [2:0]  bright = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  an;
    logic [6:0]  sev_out;
    logic        dp;
    logic        frame_done;
    logic        src_core;

    sevenseg_scan_ctrl #(.BLANK_CYC(BLANK_CYC), .ON_STEP(ON_STEP)) dut (
        .clk_7seg   (clk_7seg),
        .Rst        (Rst),
        .core_sel   (core_sel),
        .core_data  (core_data),
        .mmio_data  (mmio_data),
        .digit_en   (digit_en),
        .lz_en      (lz_en),
        .bright     (bright),
        .dp_mask    (dp_mask),
        .an         (an),
        .sev_out    (sev_out),
        .dp         (dp),
        .frame_done (frame_done),
        .src_core   (src_core)
    );

    always #5 clk_7seg = ~clk_7seg;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       src;
    } exp_t;

    typedef struct {
        logic        sel;
        logic [31:0] cd;
        logic [31:0] md;
        logic [7:0]  en;
        logic [7:0]  dpm;
        logic        lz;
        logic [2:0]  br;
    } cfg_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   frame_no = 0;
    logic prev_src = 1'b0;
    logic [6:0] dec_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    function automatic exp_t blank_exp(input logic src);
        exp_t e;
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0; e.src = src;
        return e;
    endfunction

    // Expected pins at cycle c of a frame (c=0 is the latch cycle).
    function automatic exp_t model(input int c, input cfg_t f, input logic psrc);
        exp_t e;
        int p, d, r, oc;
        logic [31:0] word, above;
        e = blank_exp((c == 0) ? psrc : f.sel);
        if (c > 0) begin
            p = c - 1;
            d = p / DIG_CYC;
            r = p % DIG_CYC;
            if (r >= BLANK_CYC) begin
                oc    = r - BLANK_CYC;
                word  = f.sel ? f.cd : f.md;
                above = word >> (4 * d);
                e.fd  = (d == 7) && (oc == 8 * ON_STEP - 1);
                if (f.en[d] && !(f.lz && d != 0 && above == 0)
                    && oc < (int'(f.br) + 1) * ON_STEP) begin
                    e.an  = ~(8'b1 << d);
                    e.seg = dec_tab[above[3:0]];
                    e.dp  = ~f.dpm[d];
                end
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk_7seg);
        #1;
    endtask

    // Entered at posedge+1 of a latch cycle; leaves at posedge+1 of the next latch cycle.
    task automatic run_frame(input cfg_t f, input int mid_at, input cfg_t mid, input int rst_at);
        core_sel = f.sel; core_data = f.cd; mmio_data = f.md;
        digit_en = f.en;  dp_mask = f.dpm;  lz_en = f.lz; bright = f.br;
        $display("frame %0d: sel=%0b word=%08h en=%02h lz=%0b br=%0d dpm=%02h mid=%0d rst=%0d",
                 frame_no, f.sel, f.sel ? f.cd : f.md, f.en, f.lz, f.br, f.dpm, mid_at, rst_at);
        frame_no++;
        for (int c = 0; c < FRAME; c++) begin
            if (c == mid_at) begin
                core_sel = mid.sel; core_data = mid.cd; mmio_data = mid.md;
            end
            exp_q.push_back(model(c, f, prev_src));
            if (c == rst_at) begin
                Rst = 1'b1;
                step();
                for (int k = 0; k < 2; k++) begin
                    exp_q.push_back(blank_exp(1'b0));
                    step();
                end
                Rst = 1'b0;
                prev_src = 1'b0;
                return;
            end
            step();
        end
        prev_src = f.sel;
    endtask

    function automatic cfg_t mk(input logic sel, input logic [31:0] cd, input logic [31:0] md,
                                input logic [7:0] en, input logic [7:0] dpm,
                                input logic lz, input logic [2:0] br);
        cfg_t f;
        f.sel = sel; f.cd = cd; f.md = md; f.en = en; f.dpm = dpm; f.lz = lz; f.br = br;
        return f;
    endfunction

    function automatic cfg_t rnd_cfg();
        cfg_t f;
        f.sel = 1'($urandom_range(0, 1));
        f.cd  = $urandom >> $urandom_range(0, 31);
        f.md  = $urandom >> $urandom_range(0, 31);
        f.en  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
        f.dpm = 8'($urandom);
        f.lz  = 1'($urandom_range(0, 1));
        f.br  = 3'($urandom_range(0, 7));
        return f;
    endfunction

    always @(negedge clk_7seg) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({an, sev_out, dp, frame_done, src_core} !== {e.an, e.seg, e.dp, e.fd, e.src}) begin
                bad++;
                $display("FAIL pins t=%0t: an=%02h seg=%02h dp=%0b fd=%0b src=%0b, need an=%02h seg=%02h dp=%0b fd=%0b src=%0b",
                         $time, an, sev_out, dp, frame_done, src_core, e.an, e.seg, e.dp, e.fd, e.src);
            end
        end
    end

    initial begin
        cfg_t f, g, none;
        none = mk(1'b0, '0, '0, '0, '0, 1'b0, 3'd0);
        @(posedge clk_7seg);
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(blank_exp(1'b0));
            step();
        end
        Rst = 1'b0;

        f = mk(1'b0, 32'h0, 32'h8765_4321, 8'hFF, 8'h00, 1'b0, 3'd7);
        run_frame(f, -1, none, -1);
        f.br = 3'd0; run_frame(f, -1, none, -1);
        f.br = 3'd3; run_frame(f, -1, none, -1);
        f = mk(1'b0, 32'h0, 32'h0000_00A0, 8'hFF, 8'h00, 1'b1, 3'd7);
        run_frame(f, -1, none, -1);
        f.md = 32'h0; run_frame(f, -1, none, -1);
        // Source switch mid-frame must only show up after the next latch.
        f = mk(1'b0, 32'h0, 32'h1234_5678, 8'hFF, 8'h00, 1'b0, 3'd7);
        g = mk(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 8'hFF, 8'h00, 1'b0, 3'd7);
        run_frame(f, 40, g, -1);
        run_frame(g, -1, none, -1);
        f = mk(1'b0, 32'h0, 32'hFEDC_BA98, 8'h0F, 8'h01, 1'b0, 3'd7);
        run_frame(f, -1, none, -1);
        f = mk(1'b1, 32'hCAFE_0123, 32'h0, 8'hFF, 8'h20, 1'b0, 3'd7);
        run_frame(f, -1, none, 1 + 5 * DIG_CYC + BLANK_CYC + 3);
        f.dpm = 8'h00; run_frame(f, -1, none, -1);

        for (int n = 0; n < 24; n++) begin
            f = rnd_cfg();
            g = rnd_cfg();
            run_frame(f, ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, FRAME - 1)) : -1, g,
                      (n % 9 == 8) ? int'($urandom_range(1, FRAME - 1)) : -1);
        end

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk_7seg);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, need 0", exp_q.size());
        end
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
